// File: rtl/menshen_frame_injector.sv
// Frame replay engine: streams a stored frame onto the H2C AXI-stream and checks
// the first beat returned on a selected CMAC TX port against an expected value.
module menshen_frame_injector #(
  parameter int          DATA_WIDTH = 512,
  parameter int          NUM_PORTS  = 2,
  parameter int          DEPTH      = 16,
  parameter int          GAP_CYCLES = 30,
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] MDATA      = 32'h4A,
  localparam int         AW         = $clog2(DEPTH),
  localparam int         PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            axis_aclk,
  input  logic                            axis_rst,
  input  logic                            mem_wr_en,
  input  logic [AW-1:0]                   mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]           mem_wr_data,
  input  logic [5:0]                      mem_wr_mty,
  input  logic                            start,
  input  logic [AW:0]                     start_len,
  input  logic [10:0]                     start_qid,
  input  logic [PW-1:0]                   start_port,
  input  logic                            start_check,
  input  logic [DATA_WIDTH-1:0]           start_expected,
  output logic [DATA_WIDTH-1:0]           m_axis_h2c_tdata,
  output logic                            m_axis_h2c_tvalid,
  output logic                            m_axis_h2c_tlast,
  input  logic                            m_axis_h2c_tready,
  output logic [5:0]                      m_axis_h2c_tuser_mty,
  output logic [10:0]                     m_axis_h2c_tuser_qid,
  output logic [31:0]                     m_axis_h2c_tuser_mdata,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tx_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tx_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tx_tready,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            fail_mismatch,
  output logic                            fail_timeout,
  output logic [DATA_WIDTH-1:0]           captured,
  output logic [15:0]                     pass_cnt,
  output logic [15:0]                     fail_cnt
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_L    = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  // Frame memory: no reset so contents survive axis_rst
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [5:0]            mem_mty  [DEPTH];

  state_t                state_q, state_d;
  logic [AW-1:0]         beat_q, beat_d, last_q, last_d;
  logic [10:0]           qid_q, qid_d;
  logic [PW-1:0]         port_q, port_d;
  logic                  check_q, check_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [5:0]            mty_q, mty_d;
  logic                  armed_q, armed_d, got_q, got_d;
  logic [DATA_WIDTH-1:0] captured_q, captured_d;
  logic                  pass_q, pass_d, mism_q, mism_d, tmo_flag_q, tmo_flag_d;
  logic                  done_q, done_d, busy_q, busy_d;
  logic [15:0]           pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [NUM_PORTS-1:0]  tx_rdy_q;

  logic [DATA_WIDTH-1:0] tx_data_arr [NUM_PORTS];
  logic [AW-1:0]         nxt_idx;
  logic [AW:0]           len_m1;
  logic [PW-1:0]         port_sel;
  logic                  hs, cap_now;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_tx
    assign tx_data_arr[gi] = s_axis_tx_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge axis_aclk) begin
    if (mem_wr_en && !busy_q) begin
      mem_data[mem_wr_addr] <= mem_wr_data;
      mem_mty[mem_wr_addr]  <= mem_wr_mty;
    end
  end

  // Zero length means one beat; lengths past the memory are clamped to DEPTH
  assign len_m1   = (start_len == '0) ? '0 :
                    ((start_len > DEPTH_L) ? DEPTH_L - 1'b1 : start_len - 1'b1);
  assign port_sel = (int'(start_port) >= NUM_PORTS) ? '0 : start_port;
  assign nxt_idx  = beat_q + 1'b1;
  assign hs       = tvalid_q && m_axis_h2c_tready;
  assign cap_now  = armed_q && !got_q && s_axis_tx_tvalid[port_q];

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_d     = last_q;
    qid_d      = qid_q;
    port_d     = port_q;
    check_d    = check_q;
    expected_d = expected_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    mty_d      = mty_q;
    armed_d    = armed_q;
    got_d      = got_q;
    captured_d = captured_q;
    pass_d     = pass_q;
    mism_d     = mism_q;
    tmo_flag_d = tmo_flag_q;
    done_d     = 1'b0;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;

    if (cap_now) begin
      got_d      = 1'b1;
      captured_d = tx_data_arr[port_q];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          last_d     = len_m1[AW-1:0];
          qid_d      = start_qid;
          port_d     = port_sel;
          check_d    = start_check;
          expected_d = start_expected;
          pass_d     = 1'b0;
          mism_d     = 1'b0;
          tmo_flag_d = 1'b0;
          armed_d    = 1'b0;
          got_d      = 1'b0;
          beat_d     = '0;
          tdata_d    = mem_data[0];
          tvalid_d   = 1'b1;
          tlast_d    = (len_m1 == '0);
          mty_d      = (len_m1 == '0) ? mem_mty[0] : 6'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (beat_q == '0 && check_q) armed_d = 1'b1;
          if (beat_q == last_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            mty_d    = 6'd0;
            tmo_d    = '0;
            gap_d    = '0;
            if (check_q) begin
              state_d = WAIT;
            end else begin
              done_d  = 1'b1;
              state_d = GAP;
            end
          end else begin
            beat_d  = nxt_idx;
            tdata_d = mem_data[nxt_idx];
            tlast_d = (nxt_idx == last_q);
            mty_d   = (nxt_idx == last_q) ? mem_mty[nxt_idx] : 6'd0;
          end
        end
      end
      WAIT: begin
        // A capture in the timeout cycle defers the verdict to the compare
        if (got_q) begin
          if (captured_q == expected_q) begin
            pass_d     = 1'b1;
            pass_cnt_d = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
          end else begin
            mism_d     = 1'b1;
            fail_cnt_d = (fail_cnt_q == 16'hFFFF) ? fail_cnt_q : fail_cnt_q + 16'd1;
          end
          armed_d = 1'b0;
          done_d  = 1'b1;
          state_d = GAP;
        end else if (tmo_q == TMO_L) begin
          if (!cap_now) begin
            tmo_flag_d = 1'b1;
            fail_cnt_d = (fail_cnt_q == 16'hFFFF) ? fail_cnt_q : fail_cnt_q + 16'd1;
            armed_d    = 1'b0;
            done_d     = 1'b1;
            state_d    = GAP;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q >= GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      last_q     <= '0;
      qid_q      <= '0;
      port_q     <= '0;
      check_q    <= 1'b0;
      expected_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      mty_q      <= '0;
      armed_q    <= 1'b0;
      got_q      <= 1'b0;
      captured_q <= '0;
      pass_q     <= 1'b0;
      mism_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      tx_rdy_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      qid_q      <= qid_d;
      port_q     <= port_d;
      check_q    <= check_d;
      expected_q <= expected_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      mty_q      <= mty_d;
      armed_q    <= armed_d;
      got_q      <= got_d;
      captured_q <= captured_d;
      pass_q     <= pass_d;
      mism_q     <= mism_d;
      tmo_flag_q <= tmo_flag_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      tx_rdy_q   <= '1;
    end
  end

  assign m_axis_h2c_tdata       = tdata_q;
  assign m_axis_h2c_tvalid      = tvalid_q;
  assign m_axis_h2c_tlast       = tlast_q;
  assign m_axis_h2c_tuser_mty   = mty_q;
  assign m_axis_h2c_tuser_qid   = qid_q;
  assign m_axis_h2c_tuser_mdata = MDATA;
  assign s_axis_tx_tready       = tx_rdy_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign pass                   = pass_q;
  assign fail_mismatch          = mism_q;
  assign fail_timeout           = tmo_flag_q;
  assign captured               = captured_q;
  assign pass_cnt               = pass_cnt_q;
  assign fail_cnt               = fail_cnt_q;

endmodule

// File: tb/tb_menshen_frame_injector.sv
// Scoreboard bench for menshen_frame_injector: expected H2C beats and run results
// are queued at stimulus time and consumed as the DUT emits beats and done pulses.
module tb_menshen_frame_injector;
  localparam int DW    = 64;
  localparam int NP    = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP   = 4;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              axis_rst;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [DW-1:0]     mem_wr_data;
  logic [5:0]        mem_wr_mty;
  logic              start;
  logic [AW:0]       start_len;
  logic [10:0]       start_qid;
  logic              start_port;
  logic              start_check;
  logic [DW-1:0]     start_expected;
  logic [DW-1:0]     tdata;
  logic              tvalid, tlast, tready;
  logic [5:0]        tmty;
  logic [10:0]       tqid;
  logic [31:0]       tmdata;
  logic [NP*DW-1:0]  tx_tdata;
  logic [NP-1:0]     tx_tvalid, tx_tready;
  logic              busy, done, pass, fail_mismatch, fail_timeout;
  logic [DW-1:0]     captured;
  logic [15:0]       pass_cnt, fail_cnt;

  menshen_frame_injector #(
    .DATA_WIDTH(DW), .NUM_PORTS(NP), .DEPTH(DEPTH),
    .GAP_CYCLES(GAP), .TIMEOUT(TMO), .MDATA(32'h4A)
  ) dut (
    .axis_aclk(clk), .axis_rst(axis_rst),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_mty(mem_wr_mty),
    .start(start), .start_len(start_len), .start_qid(start_qid),
    .start_port(start_port), .start_check(start_check),
    .start_expected(start_expected),
    .m_axis_h2c_tdata(tdata), .m_axis_h2c_tvalid(tvalid),
    .m_axis_h2c_tlast(tlast), .m_axis_h2c_tready(tready),
    .m_axis_h2c_tuser_mty(tmty), .m_axis_h2c_tuser_qid(tqid),
    .m_axis_h2c_tuser_mdata(tmdata),
    .s_axis_tx_tdata(tx_tdata), .s_axis_tx_tvalid(tx_tvalid),
    .s_axis_tx_tready(tx_tready),
    .busy(busy), .done(done), .pass(pass),
    .fail_mismatch(fail_mismatch), .fail_timeout(fail_timeout),
    .captured(captured), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [5:0]    mty;
    logic [10:0]   qid;
  } beat_t;

  typedef struct {
    logic          pass;
    logic          mism;
    logic          tmo;
    logic          cap_en;
    logic [DW-1:0] cap;
    logic [15:0]   pc;
    logic [15:0]   fc;
    int            lat;
  } res_t;

  beat_t         beat_sb [$];
  res_t          res_sb  [$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [5:0]    mty_m [DEPTH];
  int            m_pass = 0;
  int            m_fail = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            last_hs_edge = 0;
  logic          bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input int addr, input logic [DW-1:0] data,
                           input logic [5:0] mty, input bit taken);
    mem_wr_en   = 1'b1;
    mem_wr_addr = AW'(addr);
    mem_wr_data = data;
    mem_wr_mty  = mty;
    tick();
    mem_wr_en = 1'b0;
    if (taken) begin
      mem_m[addr] = data;
      mty_m[addr] = mty;
    end
  endtask

  task automatic push_beats(input int len, input logic [10:0] qid);
    int l;
    beat_t b;
    l = (len == 0) ? 1 : len;
    for (int i = 0; i < l; i++) begin
      b.data = mem_m[i];
      b.last = (i == l - 1);
      b.mty  = (i == l - 1) ? mty_m[i] : 6'd0;
      b.qid  = qid;
      beat_sb.push_back(b);
    end
  endtask

  task automatic push_res(input logic p, input logic mi, input logic to,
                          input logic cap_en, input logic [DW-1:0] cap, input int lat);
    res_t r;
    if (p) m_pass++;
    if (mi || to) m_fail++;
    r.pass = p; r.mism = mi; r.tmo = to; r.cap_en = cap_en; r.cap = cap;
    r.pc = 16'(m_pass); r.fc = 16'(m_fail); r.lat = lat;
    res_sb.push_back(r);
  endtask

  task automatic start_run(input int len, input logic [10:0] qid, input logic port,
                           input logic chk, input logic [DW-1:0] exp);
    push_beats(len, qid);
    start_len      = (AW + 1)'(len);
    start_qid      = qid;
    start_port     = port;
    start_check    = chk;
    start_expected = exp;
    start          = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 64'(busy), 64'(1));
    check("start_tvalid", 64'(tvalid), 64'(1));
  endtask

  task automatic wait_last_hs();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tvalid && tready && tlast) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("last_hs_timeout", 64'(1), 64'(0));
    tick();
  endtask

  task automatic pulse(input int port, input logic [DW-1:0] data, input int waitc);
    repeat (waitc) tick();
    tx_tdata[port*DW +: DW] = data;
    tx_tvalid[port]         = 1'b1;
    tick();
    tx_tvalid = '0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 64'(1), 64'(0));
    tick();
  endtask

  // H2C backpressure pattern 1,0,1,0 when enabled
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) tready = ~tready;
      else       tready = 1'b1;
    end
  end

  // Scoreboard consumers: beats on handshake, results on done
  initial begin
    logic          hold_v;
    logic [DW-1:0] hold_d;
    beat_t         b;
    res_t          r;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (axis_rst) begin
        hold_v = 1'b0;
        continue;
      end
      if (hold_v) begin
        check("hold_valid", 64'(tvalid), 64'(1));
        check("hold_data", 64'(tdata), 64'(hold_d));
        hold_v = 1'b0;
      end
      if (tvalid && !tready) begin
        hold_v = 1'b1;
        hold_d = tdata;
      end
      if (tvalid && tready) begin
        if (beat_sb.size() == 0) begin
          check("extra_beat", 64'(1), 64'(0));
        end else begin
          b = beat_sb.pop_front();
          check("beat_data", 64'(tdata), 64'(b.data));
          check("beat_last", 64'(tlast), 64'(b.last));
          check("beat_mty", 64'(tmty), 64'(b.mty));
          check("beat_qid", 64'(tqid), 64'(b.qid));
          check("beat_mdata", 64'(tmdata), 64'(32'h4A));
        end
        if (tlast) last_hs_edge = cyc + 1;
      end
      if (done) begin
        if (res_sb.size() == 0) begin
          check("extra_done", 64'(1), 64'(0));
        end else begin
          r = res_sb.pop_front();
          check("res_pass", 64'(pass), 64'(r.pass));
          check("res_mismatch", 64'(fail_mismatch), 64'(r.mism));
          check("res_timeout", 64'(fail_timeout), 64'(r.tmo));
          check("res_pass_cnt", 64'(pass_cnt), 64'(r.pc));
          check("res_fail_cnt", 64'(fail_cnt), 64'(r.fc));
          if (r.cap_en) check("res_captured", 64'(captured), 64'(r.cap));
          if (r.lat >= 0) check("done_latency", 64'(cyc - last_hs_edge), 64'(r.lat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] e1, e2;
    int            d_edge, n_hs;
    bit            ok;
    e1 = 64'hCAFE_0001_DEAD_BEEF;
    e2 = 64'h1234_5678_9ABC_DEF0;
    axis_rst = 1'b1; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
    mem_wr_mty = '0; start = 1'b0; start_len = '0; start_qid = '0;
    start_port = 1'b0; start_check = 1'b0; start_expected = '0;
    tx_tdata = '0; tx_tvalid = '0;
    repeat (3) tick();

    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_flags", 64'({pass, fail_mismatch, fail_timeout, tlast}), 64'(0));
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_captured", 64'(captured), 64'(0));
    check("rst_counters", 64'({pass_cnt, fail_cnt}), 64'(0));
    check("rst_tx_tready", 64'(tx_tready), 64'(0));
    axis_rst = 1'b0;
    tick();
    check("tx_tready_after_rst", 64'(tx_tready), 64'(2'b11));

    for (int i = 0; i < 4; i++)
      mem_write(i, 64'hA000_0000_0000_0000 | 64'(i * 17 + 3), (i == 2) ? 6'b001010 : 6'd0, 1'b1);

    // single-beat checked run, response 5 cycles after tlast
    push_res(1'b1, 1'b0, 1'b0, 1'b1, e1, 6);
    start_run(1, 11'd0, 1'b0, 1'b1, e1);
    wait_last_hs();
    pulse(0, e1, 4);

    // hold start through the gap: must be accepted exactly GAP+1 cycles after done
    ok = 1'b0;
    d_edge = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        d_edge = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_wait_timeout", 64'(1), 64'(0));
    push_beats(1, 11'd5);
    push_res(1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
    start_len = 5'd1; start_qid = 11'd5; start_check = 1'b0; start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) check("gap_start_timeout", 64'(1), 64'(0));
    check("gap_start_edge", 64'(cyc - d_edge), 64'(GAP + 1));
    wait_idle();

    // mismatch; start_len 0 behaves as one beat
    push_res(1'b0, 1'b1, 1'b0, 1'b1, e1 ^ 64'd1, 6);
    start_run(0, 11'h2A, 1'b0, 1'b1, e1);
    wait_last_hs();
    pulse(0, e1 ^ 64'd1, 4);
    wait_idle();

    // timeout with no response
    push_res(1'b0, 1'b0, 1'b1, 1'b0, '0, TMO + 1);
    start_run(1, 11'd3, 1'b0, 1'b1, e1);
    wait_idle();

    // three beats under backpressure; memory write while busy is dropped
    bp_en = 1'b1;
    push_res(1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
    start_run(3, 11'd7, 1'b0, 1'b0, '0);
    mem_write(0, 64'hBAD0_BAD0_BAD0_BAD0, 6'd5, 1'b0);
    wait_idle();
    bp_en = 1'b0;
    tick();

    // port select: port-0 beat ignored, port-1 beat captured
    push_res(1'b1, 1'b0, 1'b0, 1'b1, e2, 8);
    start_run(2, 11'd1, 1'b1, 1'b1, e2);
    wait_last_hs();
    pulse(0, e2, 4);
    pulse(1, e2, 1);
    wait_idle();

    // reset after beat 1 of a four-beat frame
    start_run(4, 11'd9, 1'b0, 1'b1, e1);
    n_hs = 0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tvalid && tready) n_hs++;
      if (n_hs == 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("beat1_wait_timeout", 64'(1), 64'(0));
    tick();
    axis_rst = 1'b1;
    tick();
    check("midrst_tvalid", 64'(tvalid), 64'(0));
    check("midrst_tlast", 64'(tlast), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_counters", 64'({pass_cnt, fail_cnt}), 64'(0));
    beat_sb.delete();
    res_sb.delete();
    m_pass = 0;
    m_fail = 0;
    tick();
    axis_rst = 1'b0;
    tick();
    push_res(1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
    start_run(4, 11'd1, 1'b0, 1'b0, '0);
    wait_idle();

    check("beat_sb_empty", 64'(beat_sb.size()), 64'(0));
    check("res_sb_empty", 64'(res_sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
